// File: rtl/debounce_scheduler.sv
// Shared-datapath debouncer: one round-robin visit per scan tick, commit after COUNT_MAX+1 equal visits
// (COUNT_MAX+1)*CHANNELS*TICK_DIV clk from change visit to commit; enable=0 freezes all state, pulses drop.
module debounce_scheduler #(
  parameter int CHANNELS    = 8,
  parameter int COUNT_MAX   = 255,
  parameter int COUNT_WIDTH = 8,
  parameter int TICK_DIV    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         keys_raw,
  output logic [CHANNELS-1:0]         keys_db,
  output logic [CHANNELS-1:0]         press,
  output logic [CHANNELS-1:0]         release_o,
  output logic [$clog2(CHANNELS)-1:0] scan_idx
);

  localparam int IW = $clog2(CHANNELS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]          PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0]          IDX_LAST   = IW'(CHANNELS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = COUNT_WIDTH'(COUNT_MAX);

  logic [CHANNELS-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CHANNELS-1:0]    last_q, last_d;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    db_q, db_d;
  logic [CHANNELS-1:0]    press_q, press_d;
  logic [CHANNELS-1:0]    rel_q, rel_d;
  logic                   tick;
  logic                   samp;
  logic [COUNT_WIDTH-1:0] cnt_cur;

  always_comb begin
    sync1_d = keys_raw;
    sync2_d = sync1_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = '0;
    rel_d   = '0;
    tick    = enable && (presc_q == PRESC_LAST);
    samp    = sync2_q[idx_q];
    cnt_cur = cnt_q[idx_q];

    if (enable) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (samp != last_q[idx_q]) begin
        last_d[idx_q] = samp;
        cnt_d[idx_q]  = '0;
      end else if (cnt_cur < CNT_MAX) begin
        cnt_d[idx_q] = cnt_cur + 1'b1;
      end else begin
        // Saturated: keep re-committing; only an actual level change pulses.
        db_d[idx_q] = samp;
        if (db_q[idx_q] != samp) begin
          press_d[idx_q] = samp;
          rel_d[idx_q]   = ~samp;
        end
      end
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      db_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign keys_db   = db_q;
  assign press     = press_q;
  assign release_o = rel_q;
  assign scan_idx  = idx_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: two instances (TICK_DIV 1 and 3) against a run-length reference model.
module tb_debounce_scheduler;

  localparam int CH = 4;
  localparam int CM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] keys_raw = 4'b0;

  logic [3:0] db_a, press_a, rel_a, db_b, press_b, rel_b;
  logic [1:0] idx_a, idx_b;

  debounce_scheduler #(.CHANNELS(CH), .COUNT_MAX(CM), .COUNT_WIDTH(8), .TICK_DIV(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .keys_raw(keys_raw),
    .keys_db(db_a), .press(press_a), .release_o(rel_a), .scan_idx(idx_a));

  debounce_scheduler #(.CHANNELS(CH), .COUNT_MAX(CM), .COUNT_WIDTH(8), .TICK_DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .keys_raw(keys_raw),
    .keys_db(db_b), .press(press_b), .release_o(rel_b), .scan_idx(idx_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: a visit commits once the channel has seen COUNT_MAX+2
  // consecutive equal visit samples, counting the reset state as one zero sample.
  logic [3:0] hist[$];
  int         div_m[2] = '{1, 3};
  int         en_cnt[2];
  int         tick_cnt[2];
  int         run[2][4];
  logic       lastv[2][4];
  logic [3:0] m_db[2], m_press[2], m_rel[2];

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      en_cnt[m] = 0; tick_cnt[m] = 0;
      m_db[m] = '0; m_press[m] = '0; m_rel[m] = '0;
      for (int c = 0; c < CH; c++) begin
        run[m][c] = 1; lastv[m][c] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [3:0] samp;
      samp = (hist.size() >= 2) ? hist[hist.size()-2] : 4'b0;
      for (int m = 0; m < 2; m++) begin
        m_press[m] = '0;
        m_rel[m]   = '0;
        if (enable) begin
          en_cnt[m]++;
          if (en_cnt[m] % div_m[m] == 0) begin
            int ch;
            ch = tick_cnt[m] % CH;
            if (samp[ch] == lastv[m][ch]) run[m][ch]++;
            else begin lastv[m][ch] = samp[ch]; run[m][ch] = 1; end
            if (run[m][ch] >= CM + 2) begin
              if (m_db[m][ch] != samp[ch]) begin
                m_press[m][ch] = samp[ch];
                m_rel[m][ch]   = ~samp[ch];
              end
              m_db[m][ch] = samp[ch];
            end
            tick_cnt[m]++;
          end
        end
      end
      hist.push_back(keys_raw);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  end

  bit chk_on = 1'b0;
  int cyc = 0;
  int press_cnt[4], rel_cnt[4], press_t[4], rel_t[4];

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      check("db_a", db_a, m_db[0]);
      check("press_a", press_a, m_press[0]);
      check("rel_a", rel_a, m_rel[0]);
      check("idx_a", idx_a, tick_cnt[0] % CH);
      check("db_b", db_b, m_db[1]);
      check("press_b", press_b, m_press[1]);
      check("rel_b", rel_b, m_rel[1]);
      check("idx_b", idx_b, tick_cnt[1] % CH);
      check("onehot_a", $countones(press_a | rel_a) <= 1, 1);
      check("onehot_b", $countones(press_b | rel_b) <= 1, 1);
      for (int i = 0; i < CH; i++) begin
        if (press_a[i]) begin press_cnt[i]++; press_t[i] = cyc; end
        if (rel_a[i])   begin rel_cnt[i]++;   rel_t[i]   = cyc; end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < CH; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_t[i] = 0; rel_t[i] = 0;
    end
  endtask

  initial begin
    int n;
    logic [1:0] idx_hold;
    logic [3:0] db_hold;
    model_reset();
    clr_counts();
    #2 rst_n = 1'b0;
    #1;
    chk_on = 1'b1;
    check("rst_db", db_a, 0);
    check("rst_idx", idx_a, 0);
    clks(3);
    rst_n = 1'b1;
    enable = 1'b1;

    // 1: idle scan
    clks(100);
    check("t1_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("t1_db", db_a, 0);

    // 2: single key press, latency window from raw edge
    clr_counts();
    keys_raw[2] = 1'b1;
    n = 0;
    while (!db_a[2] && n < 40) begin clks(1); n++; end
    check("t2_lat_ok", (n >= 19 && n <= 22), 1);
    clks(20);
    check("t2_db", db_a, 4'b0100);
    check("t2_press2", press_cnt[2], 1);
    check("t2_press_other", press_cnt[0] + press_cnt[1] + press_cnt[3], 0);

    // 3: short glitch rejected
    clr_counts();
    keys_raw[1] = 1'b1;
    clks(10);
    keys_raw[1] = 1'b0;
    clks(30);
    check("t3_db1", db_a[1], 0);
    check("t3_press1", press_cnt[1], 0);

    // 4: all keys at once, staggered pulses
    keys_raw = 4'b0;
    clks(40);
    clr_counts();
    keys_raw = 4'hF;
    clks(40);
    check("t4_db", db_a, 4'hF);
    for (int i = 0; i < CH; i++) check("t4_press_once", press_cnt[i], 1);
    check("t4_press_span", (press_t[3] - press_t[0] + 4) % 4 == 3 &&
          $countones({press_t[0] != press_t[1], press_t[1] != press_t[2], press_t[2] != press_t[3]}) == 3, 1);
    keys_raw = 4'h0;
    clks(40);
    check("t4_db_rel", db_a, 4'h0);
    for (int i = 0; i < CH; i++) check("t4_rel_once", rel_cnt[i], 1);
    check("t4_rel_distinct", rel_t[0] != rel_t[1] && rel_t[1] != rel_t[2] &&
          rel_t[2] != rel_t[3] && rel_t[0] != rel_t[2] && rel_t[1] != rel_t[3] && rel_t[0] != rel_t[3], 1);

    // 5: reset mid-count
    keys_raw = 4'b0001;
    clks(40);
    keys_raw[2] = 1'b1;
    n = 0;
    while (!(lastv[0][2] == 1'b1 && run[0][2] == 3) && n < 60) begin clks(1); n++; end
    check("t5_reached_cnt2", n < 60, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_db", db_a, 0);
    check("t5_rst_idx", idx_a, 0);
    check("t5_rst_press", press_a | rel_a, 0);
    clks(2);
    rst_n = 1'b1;
    n = 0;
    while (!db_a[2] && n < 40) begin clks(1); n++; end
    check("t5_relatch", n, 19);

    // 6: enable freeze, then TICK_DIV=3 stepping
    keys_raw = 4'b1000;
    clks(7);
    idx_hold = idx_a;
    db_hold = db_a;
    clr_counts();
    enable = 1'b0;
    clks(50);
    check("t6_idx_frozen", idx_a, idx_hold);
    check("t6_db_frozen", db_a, db_hold);
    check("t6_no_pulse", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
          + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
    enable = 1'b1;
    idx_hold = idx_b;
    clks(3);
    check("t6_div3_step", idx_b, 2'(idx_hold + 2'd1));
    clks(60);
    check("t6_db_resumed", db_a, 4'b1000);

    // Random phase
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) keys_raw[$urandom_range(0, 3)] ^= 1'b1;
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
      end
      clks(1);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
